shift_right_seq_32: RTL and testbench
=====================================

Name: shift_right_seq_32

Overview:
- Iterative 32-bit right shifter, one bit position per clock, with logical or arithmetic fill.
- It is the right-shift counterpart to the datapath's combinational left-shift-by-two: it serves SRL/SRA-class ALU operations in the multi-cycle datapath.
- A start/busy/done handshake is used, so the controller can stall while the shift runs.
- Result is held in an output register until the next accepted start.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- data_i  in  WIDTH  operand; captured on accepted start.
- shamt_i  in  SHAMT_W  shift amount 0..WIDTH-1; captured on accepted start.
- arith_i  in  1  1 = arithmetic (replicate operand MSB), 0 = logical (zero fill); captured on accepted start.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse; data_o valid and updated in that cycle.
- data_o  out  WIDTH  result register.

Behaviour:
- Reset: rst_i high at an edge forces the following, regardless of state; any in-flight operation is abandoned with no done_o.
  - state=IDLE, busy_o=0, done_o=0, data_o=0.
  - Working register and counter cleared.
- State machine, states IDLE, SHIFT, DONE:
  - IDLE: when start_i=1 at an edge, load work<=data_i, cnt<=shamt_i, fill<=arith_i & data_i[WIDTH-1]; go to SHIFT. With start_i=0, stay in IDLE.
  - SHIFT: at each edge with cnt!=0, work<={fill, work[WIDTH-1:1]} and cnt<=cnt-1. At the edge with cnt==0, data_o<=work and go to DONE.
  - DONE: done_o=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Latency: start sampled at edge E0; done_o is high in the cycle after edge E(shamt+1).
  - shamt=0 gives done_o one cycle after the start edge.
  - shamt=31 gives done_o 32 cycles after the start edge.
- busy_o is high in the SHIFT and DONE cycles, i.e. shamt+2 cycles total.
- start_i is ignored in SHIFT and DONE: no queuing and no effect on the running operation.
  - The earliest new accept is the first IDLE cycle after DONE, so back-to-back throughput is one operation per shamt+3 cycles.
- Inputs data_i, shamt_i and arith_i may change freely after the accept edge; only the captured values are used.
- Fill bit is fixed at capture, so an arithmetic shift of a negative operand fills with 1s for every step.
- data_o changes only on entry to DONE (or on reset); it holds the previous result throughout SHIFT.
- done_o and busy_o are registered (driven from state), with no combinational path from inputs to outputs.
- Simultaneous rst_i and start_i: reset wins, operation not accepted.

Test Plan:
- Reset, then data_i=0x80000000, shamt_i=4, arith_i=0, one-cycle start: data_o=0x08000000; done_o pulses exactly 5 cycles after the start edge; busy_o high 6 cycles.
- Same operand, arith_i=1: data_o=0xF8000000. Repeat with data_i=0x80000000, shamt_i=31, arith_i=1: data_o=0xFFFFFFFF, done_o 32 cycles after start. With arith_i=0 the result is 0x00000001.
- shamt_i=0, data_i=0x12345678, either mode: data_o=0x12345678 and done_o exactly 1 cycle after start; positive operand 0x7FFFFFF0 with arith_i=1 and shamt_i=4 gives 0x07FFFFFF.
- Start shamt_i=8 on 0xAABBCCDD; change data_i and pulse start_i during SHIFT and during the DONE cycle.
  - Required: a single result 0x00AABBCC and a single done_o pulse.
  - A start asserted in the following IDLE cycle is accepted.
- Start shamt_i=20, assert rst_i for one cycle at cycle 7: next cycle busy_o=0, done_o=0, data_o=0, and no done_o pulse ever follows. Also assert rst_i and start_i together: the start is not accepted.
- Randomized regression, 1000 operations over all shamt and both modes against a >> / >>> reference model, checking result and the exact shamt+1 latency.

Source files
------------

// File: rtl/shift_right_seq_32.sv
// Iterative right shifter: one bit per clock, logical or arithmetic fill,
// with a start/busy/done handshake and a held result register.
module shift_right_seq_32 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;

    // Control, datapath and registered handshake outputs share one process.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            data_o <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        work   <= data_i;
                        cnt    <= shamt_i;
                        // Fill bit frozen at capture so every step uses the original sign.
                        fill   <= arith_i & data_i[WIDTH-1];
                        busy_o <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= {fill, work[WIDTH-1:1]};
                        cnt  <= cnt - SHAMT_W'(1);
                    end else begin
                        data_o <= work;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq_32.sv
// Directed and random checks for the iterative right shifter.
module tb_shift_right_seq_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int checks = 0;
    int errors = 0;

    shift_right_seq_32 dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .data_i  (data_in),
        .shamt_i (shamt),
        .arith_i (arith),
        .busy_o  (busy),
        .done_o  (done),
        .data_o  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait for done; checks latency, busy span, result.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp, input bit full);
        int n;
        int busy_cycles;
        data_in = d;
        shamt   = s;
        arith   = a;
        start   = 1'b1;
        step();
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~s;
        arith   = ~a;
        n = 0;
        busy_cycles = busy ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
            if (busy === 1'b1) busy_cycles++;
        end
        check({tag, " latency"}, 32'(n), 32'(s) + 32'd1);
        check({tag, " result"}, data_out, exp);
        if (full) begin
            step();
            check({tag, " busy span"}, 32'(busy_cycles), 32'(s) + 32'd2);
            check({tag, " idle busy"}, 32'(busy), 32'd0);
            check({tag, " idle done"}, 32'(done), 32'd0);
        end else begin
            step();
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;

        rst = 1'b1; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset data", data_out, 32'h0);

        run_op("srl4",    32'h80000000, 5'd4,  1'b0, 32'h08000000, 1'b1);
        run_op("sra4",    32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1'b1);
        run_op("sra31",   32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b1);
        run_op("srl31",   32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b1);
        run_op("srl0",    32'h12345678, 5'd0,  1'b0, 32'h12345678, 1'b1);
        run_op("sra0",    32'h12345678, 5'd0,  1'b1, 32'h12345678, 1'b1);
        run_op("sra_pos", 32'h7FFFFFF0, 5'd4,  1'b1, 32'h07FFFFFF, 1'b1);

        // Starts during SHIFT and DONE must be ignored.
        data_in = 32'hAABBCCDD; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 3) begin
                data_in = 32'h11111111; shamt = 5'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        check("ignore latency", 32'(n), 32'd9);
        check("ignore result", data_out, 32'h00AABBCC);
        start = 1'b1;
        data_in = 32'h22222222;
        step();
        start = 1'b0;
        check("after done busy", 32'(busy), 32'd0);
        check("after done data", data_out, 32'h00AABBCC);
        for (int i = 0; i < 15; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("ignore extra pulses", 32'(pulses), 32'd0);
        run_op("idle accept", 32'hCAFEF00D, 5'd0, 1'b0, 32'hCAFEF00D, 1'b1);

        // Mid-flight reset abandons the operation.
        data_in = 32'hFFFF0000; shamt = 5'd20; arith = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst data", data_out, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("midrst no done", 32'(pulses), 32'd0);

        // Reset and start together: reset wins.
        data_in = 32'h80000000; shamt = 5'd3; start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", 32'(busy), 32'd0);
        step();
        check("rst+start busy2", 32'(busy), 32'd0);
        check("rst+start done", 32'(done), 32'd0);

        // Random regression against a shift-operator reference.
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            exp = a ? 32'($signed(d) >>> s) : (d >> s);
            run_op("rand", d, s, a, exp, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
